// File: rtl/ntt_pkg.sv
// Shared constants for the Goldilocks field p = 2^64 - 2^32 + 1 used by the NTT datapath.
package ntt_pkg;

    localparam int DW  = 64;
    localparam int LAT = 4;

    localparam logic [63:0] P_GOLD   = 64'hffffffff00000001;
    localparam logic [63:0] EPS_GOLD = 64'h00000000ffffffff;

    // Four 32x32 partial products of a 64x64 multiply, each held as 64 bits.
    typedef struct packed {
        logic [63:0] hh;
        logic [63:0] hl;
        logic [63:0] lh;
        logic [63:0] ll;
    } pp_t;

endpackage

// File: rtl/gold_reduce128.sv
// Combinational reduction of a 128-bit product to its canonical residue mod p.
module gold_reduce128
    import ntt_pkg::*;
(
    input  logic [2*DW-1:0] i_prod,
    output logic [DW-1:0]   o_res
);

    logic [DW-1:0] w_lo;
    logic [DW-1:0] w_a;
    logic [31:0]   w_b;
    logic [DW:0]   w_diff;
    logic [DW-1:0] w_t;
    logic [DW-1:0] w_u;
    logic [DW:0]   w_sum;
    logic [DW-1:0] w_s;

    // 2^64 == EPS and 2^96 == -1 (mod p), so P == lo - A + B*EPS.
    assign w_lo   = i_prod[63:0];
    assign w_a    = {32'b0, i_prod[127:96]};
    assign w_b    = i_prod[95:64];

    assign w_diff = {1'b0, w_lo} - {1'b0, w_a};
    assign w_t    = w_diff[DW] ? (w_diff[DW-1:0] - EPS_GOLD) : w_diff[DW-1:0];

    assign w_u    = {w_b, 32'b0} - {32'b0, w_b};

    assign w_sum  = {1'b0, w_t} + {1'b0, w_u};
    assign w_s    = w_sum[DW] ? (w_sum[DW-1:0] + EPS_GOLD) : w_sum[DW-1:0];

    assign o_res  = (w_s >= P_GOLD) ? (w_s - P_GOLD) : w_s;

endmodule

// File: rtl/tw_modmul_gold.sv
// Four-stage pipelined a*w mod p multiplier with valid/tag passthrough and active-low enable.
module tw_modmul_gold
    import ntt_pkg::*;
#(
    parameter int TAG_W = 8
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             CEN,
    input  logic             in_valid,
    input  logic [DW-1:0]    data_in,
    input  logic [DW-1:0]    tw_in,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    output logic [DW-1:0]    data_out,
    output logic [TAG_W-1:0] tag_out
);

    logic [DW-1:0]    r1_a;
    logic [DW-1:0]    r1_w;
    logic [TAG_W-1:0] r1_tag;
    logic             r1_vld;

    pp_t              r2_pp;
    logic [TAG_W-1:0] r2_tag;
    logic             r2_vld;

    logic [2*DW-1:0]  r3_prod;
    logic [TAG_W-1:0] r3_tag;
    logic             r3_vld;

    pp_t              w_pp;
    logic [2*DW-1:0]  w_prod;
    logic [DW-1:0]    w_red;

    assign w_pp.ll = {32'b0, r1_a[31:0]}  * {32'b0, r1_w[31:0]};
    assign w_pp.lh = {32'b0, r1_a[31:0]}  * {32'b0, r1_w[63:32]};
    assign w_pp.hl = {32'b0, r1_a[63:32]} * {32'b0, r1_w[31:0]};
    assign w_pp.hh = {32'b0, r1_a[63:32]} * {32'b0, r1_w[63:32]};

    assign w_prod = {64'b0, r2_pp.ll}
                  + {32'b0, r2_pp.lh, 32'b0}
                  + {32'b0, r2_pp.hl, 32'b0}
                  + {r2_pp.hh, 64'b0};

    gold_reduce128 u_reduce (
        .i_prod (r3_prod),
        .o_res  (w_red)
    );

    // NOTE: sequential state uses non-blocking assignments so every stage samples the
    // previous stage's pre-edge value; blocking here would collapse the pipeline.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r1_a      <= '0;
            r1_w      <= '0;
            r1_tag    <= '0;
            r1_vld    <= 1'b0;
            r2_pp     <= '0;
            r2_tag    <= '0;
            r2_vld    <= 1'b0;
            r3_prod   <= '0;
            r3_tag    <= '0;
            r3_vld    <= 1'b0;
            out_valid <= 1'b0;
            data_out  <= '0;
            tag_out   <= '0;
        end else if (!CEN) begin
            r1_a      <= data_in;
            r1_w      <= tw_in;
            r1_tag    <= tag_in;
            r1_vld    <= in_valid;
            r2_pp     <= w_pp;
            r2_tag    <= r1_tag;
            r2_vld    <= r1_vld;
            r3_prod   <= w_prod;
            r3_tag    <= r2_tag;
            r3_vld    <= r2_vld;
            out_valid <= r3_vld;
            data_out  <= w_red;
            tag_out   <= r3_tag;
        end
    end

endmodule
